// File: rtl/pq_access_arbiter_if.sv
// Requester-side and queue-side signal bundle for pq_access_arbiter.
// master = arbiter view; slave = requesters/queue/testbench view.
interface pq_access_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16
);
    localparam int ID_WIDTH = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0][1:0]            req_op;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;

    logic                  rsp_valid;
    logic [ID_WIDTH-1:0]   rsp_id;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;

    logic                  q_wrt;
    logic                  q_read;
    logic [DATA_WIDTH-1:0] q_data;
    logic                  q_full;
    logic                  q_empty;
    logic [DATA_WIDTH-1:0] q_top;

    modport master (
        input  req_valid, req_op, req_data, q_full, q_empty, q_top,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, q_wrt, q_read, q_data
    );

    modport slave (
        output req_valid, req_op, req_data, q_full, q_empty, q_top,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, q_wrt, q_read, q_data
    );
endinterface

// File: rtl/pq_access_arbiter.sv
// Round-robin arbiter sharing one heap priority queue between NUM_REQ requesters,
// one command at a time with an OP_GAP settle window for the queue's sift sequence.
module pq_arb_lane (
    input  logic [1:0] op,
    input  logic       q_full,
    input  logic       q_empty,
    output logic       legal
);
    always_comb begin
        case (op)
            2'b01:        legal = !q_full;
            2'b10, 2'b11: legal = !q_empty;
            default:      legal = 1'b0;
        endcase
    end
endmodule

module pq_access_arbiter #(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 16,
    parameter int  OP_GAP     = 3,
    localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                 CLK,
    input  logic                 RST,
    pq_access_arbiter_if.master  bus
);
    localparam int GAP_W = $clog2(OP_GAP + 1);
    localparam int CW    = ID_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, SETTLE} state_t;

    state_t                state, state_nxt;
    logic [ID_WIDTH-1:0]   rr_ptr, gnt_idx, lat_id, rsp_id_q;
    logic [CW-1:0]         cand;
    logic                  gnt_found, gnt_legal;
    logic [NUM_REQ-1:0]    lane_legal, req_ready_c;
    logic [1:0]            lat_op;
    logic [DATA_WIDTH-1:0] lat_data, rsp_data_q;
    logic                  rsp_valid_q, rsp_err_q;
    logic [GAP_W-1:0]      gap_cnt;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        pq_arb_lane u_lane (
            .op      (bus.req_op[g]),
            .q_full  (bus.q_full),
            .q_empty (bus.q_empty),
            .legal   (lane_legal[g])
        );
    end

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + CW'(i);
            if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
            if (!gnt_found && bus.req_valid[cand[ID_WIDTH-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[ID_WIDTH-1:0];
            end
        end
    end

    assign gnt_legal = lane_legal[gnt_idx];

    always_comb begin
        req_ready_c = '0;
        if (state == IDLE && gnt_found && !RST) req_ready_c[gnt_idx] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_found) state_nxt = gnt_legal ? ISSUE : RESP;
            ISSUE:   state_nxt = RESP;
            RESP:    state_nxt = rsp_err_q ? IDLE : SETTLE;
            SETTLE:  if (gap_cnt == GAP_W'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            gap_cnt     <= '0;
            lat_id      <= '0;
            lat_op      <= '0;
            lat_data    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            rsp_valid_q <= 1'b0;
            case (state)
                IDLE: if (gnt_found) begin
                    lat_id   <= gnt_idx;
                    lat_op   <= bus.req_op[gnt_idx];
                    lat_data <= bus.req_data[gnt_idx];
                    rr_ptr   <= (gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_WIDTH'(1);
                    // Rejected ops answer straight from IDLE; the queue never sees them.
                    if (!gnt_legal) begin
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= gnt_idx;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                    end
                end
                ISSUE: begin
                    rsp_valid_q <= 1'b1;
                    rsp_id_q    <= lat_id;
                    rsp_data_q  <= (lat_op == 2'b01) ? '0 : bus.q_top;
                    rsp_err_q   <= 1'b0;
                end
                RESP:    if (!rsp_err_q) gap_cnt <= GAP_W'(OP_GAP);
                SETTLE:  gap_cnt <= gap_cnt - GAP_W'(1);
                default: ;
            endcase
        end
    end

    // Only legal ops reach ISSUE, so op[0] = write (enq/replace), op[1] = read (deq/replace).
    assign bus.q_wrt     = (state == ISSUE) & lat_op[0];
    assign bus.q_read    = (state == ISSUE) & lat_op[1];
    assign bus.q_data    = (state == ISSUE) ? lat_data : '0;
    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: doc/pq_access_arbiter.md
Name: pq_access_arbiter

Overview:
- Shares one heap-based priority queue between NUM_REQ requesters.
- Arbitrates round-robin and issues one enqueue/dequeue/replace at a time on the queue's i_wrt/i_read/i_data interface.
- Holds off further commands for OP_GAP settle cycles so the queue's read/compare/write sift sequence can finish.
- Returns a per-operation response (requester id, popped value, error flag) and rejects illegal ops (enqueue when full, dequeue when empty) without touching the queue.

Parameters:
- NUM_REQ, 4, number of requester ports (>=2).
- DATA_WIDTH, 16, key width; must match the queue.
- OP_GAP, 3, idle cycles after each issued command before the next grant (>=1).
- ID_WIDTH, $clog2(NUM_REQ), width of rsp_id (derived, not overridden).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid&ready.
- req_op  in  2*NUM_REQ  per-requester op code, slice [2i+1:2i]: 01 enqueue, 10 dequeue, 11 replace, 00 illegal.
- req_data  in  NUM_REQ*DATA_WIDTH  per-requester key, slice i.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  ID_WIDTH  index of the requester being answered.
- rsp_data  out  DATA_WIDTH  pre-op heap top for dequeue/replace; 0 for enqueue and errors.
- rsp_err  out  1  op was rejected.
- q_wrt  out  1  queue write command.
- q_read  out  1  queue read command.
- q_data  out  DATA_WIDTH  queue insert/replace data.
- q_full  in  1  queue full flag.
- q_empty  in  1  queue empty flag.
- q_top  in  DATA_WIDTH  queue root value (queue o_data).

Behaviour:
- Single clock domain. Reset is synchronous and active-high, name RST, clock name CLK.
- Reset values: every output 0, state IDLE, rr_ptr 0, gap counter 0.
- FSM states: IDLE, ISSUE, RESP, SETTLE.
- IDLE:
  - Grant the first valid requester starting at rr_ptr, wrapping modulo NUM_REQ.
  - Drive req_ready one-hot for that requester for exactly this cycle.
  - Latch id, op and data. Set rr_ptr = granted+1, wrapping NUM_REQ-1 -> 0.
  - Legality is checked against q_full/q_empty sampled in this cycle:
    - Enqueue with q_full=1 is illegal.
    - Dequeue or replace with q_empty=1 is illegal.
    - Op 00 is illegal.
  - Illegal op -> RESP with error latched. Legal op -> ISSUE. No valid requester -> stay in IDLE.
- ISSUE (one cycle):
  - Enqueue: q_wrt=1, q_read=0. Dequeue: q_wrt=0, q_read=1. Replace: q_wrt=1, q_read=1.
  - q_data = latched data; q_data is 0 whenever no command is issued.
  - Capture q_top into the response register.
  - -> RESP.
- RESP (one cycle):
  - rsp_valid=1 with rsp_id, rsp_data and rsp_err.
  - Legal op -> SETTLE with the counter loaded to OP_GAP. Error -> IDLE directly; the queue sees no command.
- SETTLE:
  - Decrement the counter each cycle; -> IDLE when it reaches 1.
  - Duration is exactly OP_GAP cycles.
- Latency, legal op: grant at cycle T, q_* command at T+1, rsp_valid at T+2, earliest next grant at T+3+OP_GAP.
- Latency, illegal op: grant at T, rsp_valid with rsp_err=1 at T+1, next grant at T+2.
- q_wrt and q_read are never high for more than one consecutive cycle, and never high outside ISSUE.
- Requesters hold valid/op/data stable until ready. The block ignores req_* outside IDLE.
- A requester may drop valid before it is granted; this has no side effect.
- Requests from the same requester are served in order. A starved requester waits at most NUM_REQ-1 grants.
- There is no response backpressure. rsp_* hold their last values when rsp_valid=0, except rsp_valid itself.
- Reset mid-operation: the in-flight op is abandoned and no response is produced. Outputs return to 0 the cycle after RST is sampled high.
- rr_ptr and the gap counter are unsigned and wrap only as stated. The gap counter width is $clog2(OP_GAP+1).

Test Plan:
1. Reset, then requester 2 enqueues 0x0005 (q_empty=1, q_full=0) -> req_ready=4'b0100 at T, q_wrt=1/q_read=0/q_data=0x0005 at T+1, rsp_valid=1 rsp_id=2 rsp_err=0 rsp_data=0 at T+2, next grant no earlier than T+6.
2. All four requesters valid, legal enqueues -> grants in order 0,1,2,3,0, spaced exactly 3+OP_GAP=6 cycles apart; rsp_id follows the same order.
3. Requester 1 dequeues with q_empty=1 -> rsp_valid at T+1 with rsp_err=1, rsp_data=0; q_wrt/q_read stay 0 throughout; next grant at T+2.
4. Replace 0x0003 with q_top=0x0009, q_empty=0 -> q_wrt=1 and q_read=1 for one cycle with q_data=0x0003; rsp_data=0x0009, rsp_err=0.
5. Enqueue with q_full=1, plus op 00 from another requester -> both rejected with rsp_err=1 and no q_* activity.
6. Assert RST during SETTLE, and separately during ISSUE -> no rsp_valid for the abandoned op, all outputs 0 next cycle, rr_ptr=0 so requester 0 wins the next contest.
